// File: rtl/switch_input_conditioner.sv
// Slide-switch input stage: per-channel synchroniser, debounce FSM and
// registered rise/fall event pulses, plus a combined change strobe.

module switch_input_conditioner_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic evt_d
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_STABLE, ST_COUNTING} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sw_sync;

  // Shift the raw pin through the synchroniser; nothing else touches sw_raw.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  assign sw_sync = sync_q[SYNC_STAGES-1];

  // Debounce: a new level must disagree with sw_clean for DEBOUNCE_CYCLES
  // consecutive cycles; any bounce back to the old level restarts the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sw_sync != clean_q) begin
          state_d = ST_COUNTING;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        if (sw_sync == clean_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          clean_d = sw_sync;
          rise_d  = sw_sync;
          fall_d  = ~sw_sync;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  // All channel state, including the event pulses, is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_STABLE;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign evt_d    = rise_d | fall_d;
endmodule

module switch_input_conditioner #(
  parameter int N_CH            = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] sw_raw,
  output logic [N_CH-1:0] sw_clean,
  output logic [N_CH-1:0] sw_rise,
  output logic [N_CH-1:0] sw_fall,
  output logic            sw_changed
);
  logic [N_CH-1:0] evt_d;
  logic            changed_q, changed_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    switch_input_conditioner_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw[i]),
      .sw_clean(sw_clean[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i]),
      .evt_d   (evt_d[i])
    );
  end

  // Change strobe registered from the channels' next-pulse terms so it
  // lines up with sw_rise/sw_fall in the same cycle.
  always_comb begin
    changed_d = |evt_d;
  end

  // Register the combined change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed_q <= 1'b0;
    else        changed_q <= changed_d;
  end

  assign sw_changed = changed_q;
endmodule

// File: tb/tb_switch_input_conditioner.sv
// Bench for switch_input_conditioner: directed scenarios plus random switch
// activity, every cycle compared against a run-length debounce model.

module tb_switch_input_conditioner;
  localparam int N   = 3;
  localparam int SYN = 2;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_clean, sw_rise, sw_fall;
  logic         sw_changed;

  int n_chk = 0;
  int n_err = 0;

  // model state: delay line of raw samples, accepted level, run lengths
  logic [N-1:0] rh [SYN];
  logic [N-1:0] m_clean, m_rise, m_fall;
  int           m_run [N];

  switch_input_conditioner #(
    .N_CH(N), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < SYN; k++) rh[k] = '0;
    m_clean = '0; m_rise = '0; m_fall = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
  endtask

  // Spec rule: the synchronised level is the pin as sampled SYN edges ago;
  // it is accepted once it has disagreed with the clean level for DEB
  // consecutive edges.
  task automatic m_edge();
    logic [N-1:0] s;
    s = rh[SYN-1];
    m_rise = '0; m_fall = '0;
    for (int c = 0; c < N; c++) begin
      if (s[c] != m_clean[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_clean[c] = s[c];
          m_rise[c]  = s[c];
          m_fall[c]  = ~s[c];
          m_run[c]   = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    for (int k = SYN-1; k > 0; k--) rh[k] = rh[k-1];
    rh[0] = sw_raw;
  endtask

  task automatic cmp_all(input string tag);
    check({tag, ".clean"},   32'(sw_clean),   32'(m_clean));
    check({tag, ".rise"},    32'(sw_rise),    32'(m_rise));
    check({tag, ".fall"},    32'(sw_fall),    32'(m_fall));
    check({tag, ".changed"}, 32'(sw_changed), 32'(|(m_rise | m_fall)));
  endtask

  // Drive one cycle: set pin, take the edge, advance model, compare.
  task automatic step(input logic [N-1:0] v, input string tag);
    sw_raw = v;
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_edge();
    #1;
    cmp_all(tag);
  endtask

  initial begin
    int k;
    m_reset();

    // 1: reset with all switches up, then release
    sw_raw = 3'b111;
    for (int i = 0; i < 3; i++) step(3'b111, "t1_rst");
    check("t1_clean_in_rst", 32'(sw_clean), 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(3'b111, "t1");
      if (i == 5) check("t1_clean_e5", 32'(sw_clean), 32'h0);
      if (i == 6) begin
        check("t1_clean_e6", 32'(sw_clean), 32'h7);
        check("t1_rise_e6",  32'(sw_rise),  32'h7);
        check("t1_chg_e6",   32'(sw_changed), 32'h1);
      end
    end
    step(3'b111, "t1_after");
    check("t1_rise_gone", 32'(sw_rise), 32'h0);

    // 2: clean single edge
    for (int i = 0; i < 8; i++) step(3'b000, "t2_pre");
    for (int i = 1; i <= 6; i++) begin
      step(3'b001, "t2");
      check("t2_fall", 32'(sw_fall), 32'h0);
      if (i == 6) begin
        check("t2_clean_e6", 32'(sw_clean), 32'h1);
        check("t2_rise_e6",  32'(sw_rise),  32'h1);
      end
    end

    // 3: bounce on ch1 then hold
    step(3'b001, "t3_b"); step(3'b011, "t3_b");
    step(3'b001, "t3_b"); step(3'b011, "t3_b");
    for (int i = 0; i < 8; i++) step(3'b011, "t3_hold");
    for (int i = 0; i < 8; i++) step(3'b001, "t3_back");

    // 4: 3-cycle glitch on ch2 must vanish
    for (int i = 0; i < 3; i++) step(3'b101, "t4_g");
    for (int i = 0; i < 8; i++) begin
      step(3'b001, "t4");
      check("t4_clean2", 32'(sw_clean[2]), 32'h0);
    end

    // 5: simultaneous rise and fall
    for (int i = 0; i < 8; i++) step(3'b101, "t5_pre");
    for (int i = 1; i <= 6; i++) begin
      step(3'b010, "t5");
      if (i == 6) begin
        check("t5_clean", 32'(sw_clean), 32'h2);
        check("t5_rise",  32'(sw_rise),  32'h2);
        check("t5_fall",  32'(sw_fall),  32'h5);
        check("t5_chg",   32'(sw_changed), 32'h1);
      end
    end

    // 6: reset in the middle of a count, asserted between edges
    for (int i = 0; i < 4; i++) step(3'b011, "t6_cnt");
    #2 rst_n = 1'b0;
    #1 m_reset();
    check("t6_async_clean", 32'(sw_clean), 32'h0);
    check("t6_async_rf",    32'({sw_rise, sw_fall, sw_changed}), 32'h0);
    step(3'b011, "t6_rst");
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(3'b011, "t6");
      if (i == 6) check("t6_rise_e6", 32'(sw_rise), 32'h3);
    end

    // random activity with varying bounce density and occasional resets
    k = 1;
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] v;
      if (i % 50 == 0) k = $urandom_range(0, 9);
      v = sw_raw;
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, k) == 0) v[c] = ~v[c];
      if ($urandom_range(0, 149) == 0) begin
        #3 rst_n = 1'b0;
        #1 m_reset();
        check("rnd_async_clean", 32'(sw_clean), 32'h0);
        step(v, "rnd_rst");
        rst_n = 1'b1;
      end else begin
        step(v, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
